// File: rtl/max_unpool_stream.sv
// max_unpool_stream: streaming 2x2 max-unpooling, the inverse of a 2x2 max-pool.
// One pooled row of {value, argmax index} is buffered. It is then expanded into
// two output rows (top and bottom of each 2x2 window). Each value lands on its
// argmax position and every other position is zero. Channels follow one
// another, channel-major.
//
// Build option UNPOOL_NEAREST_EN: when defined, the argmax index is ignored and
// not stored. Every pixel of the 2x2 window then carries the pooled value, which
// gives a nearest-neighbour 2x upsample. Handshake and timing are unchanged.
module max_unpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int OutH       = 28,
  parameter int OutW       = 28,
  parameter int Depth      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                   in_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         frame_done
);

  localparam int PoolW = OutW / 2;
  localparam int PoolH = OutH / 2;
  localparam int ColW  = (PoolW > 1) ? $clog2(PoolW) : 1;
  localparam int OcolW = $clog2(OutW);
  localparam int ProwW = (PoolH > 1) ? $clog2(PoolH) : 1;
  localparam int ChanW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [ColW-1:0]  ColLast  = ColW'(PoolW - 1);
  localparam logic [OcolW-1:0] OcolLast = OcolW'(OutW - 1);
  localparam logic [ProwW-1:0] ProwLast = ProwW'(PoolH - 1);
  localparam logic [ChanW-1:0] ChanLast = ChanW'(Depth - 1);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT_TOP = 2'd1,
    EMIT_BOT = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  // Position counters: pooled column being filled, output column being
  // emitted, pooled row pair and channel within the frame.
  logic [ColW-1:0]  col;
  logic [OcolW-1:0] ocol;
  logic [ProwW-1:0] prow;
  logic [ChanW-1:0] chan;

  // One pooled row. Not cleared: every entry is rewritten in FILL before
  // the following EMIT phases read it.
  logic signed [DATA_WIDTH-1:0] bufData [PoolW];
`ifndef UNPOOL_NEAREST_EN
  logic [1:0]                   bufIdx  [PoolW];
`endif

  logic                         fillState;
  logic                         emitting;
  logic                         acceptIn;
  logic                         acceptOut;
  logic                         colAtLast;
  logic                         ocolAtLast;
  logic                         prowAtLast;
  logic                         chanAtLast;
  logic                         frameEnd;
  logic [ColW-1:0]              rdCol;
  logic signed [DATA_WIDTH-1:0] pixel;

  // A pooled value goes on the output only at its recorded argmax position
  // inside the 2x2 window. Every other position of the window is zero.
  function automatic logic signed [DATA_WIDTH-1:0] placePixel(
    input logic signed [DATA_WIDTH-1:0] value,
    input logic [1:0]                   storedIdx,
    input logic [1:0]                   position
  );
    placePixel = (storedIdx == position) ? value : '0;
  endfunction

  assign fillState  = (state == FILL);
  assign emitting   = (state == EMIT_TOP) || (state == EMIT_BOT);

  // Handshake qualifiers are built from the state, not from the ready and
  // valid ports, so the next-state logic has no combinational loop through
  // in_ready.
  assign acceptIn   = fillState && in_valid;
  assign acceptOut  = emitting && out_ready;

  assign colAtLast  = (col == ColLast);
  assign ocolAtLast = (ocol == OcolLast);
  assign prowAtLast = (prow == ProwLast);
  assign chanAtLast = (chan == ChanLast);

  // Final pixel of a channel map: bottom row, last column, last row pair.
  assign frameEnd   = (state == EMIT_BOT) && ocolAtLast && prowAtLast;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and handshake outputs. FILL and EMIT never overlap, so
  // in_ready and out_valid are never high together.
  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = !reset;
        if (acceptIn && colAtLast) begin
          stateNext = EMIT_TOP;
        end
      end
      EMIT_TOP: begin
        out_valid = 1'b1;
        if (acceptOut && ocolAtLast) begin
          stateNext = EMIT_BOT;
        end
      end
      EMIT_BOT: begin
        out_valid = 1'b1;
        if (acceptOut && ocolAtLast) begin
          stateNext = FILL;
        end
      end
      default: begin
        stateNext = FILL;
      end
    endcase
  end

  // Column, row-pair and channel counters. They advance only on accepted
  // transfers, so they hold through input gaps and output stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col  <= '0;
      ocol <= '0;
      prow <= '0;
      chan <= '0;
    end else begin
      if (acceptIn) begin
        col <= colAtLast ? '0 : col + ColW'(1);
      end
      if (acceptOut) begin
        if (ocolAtLast) begin
          ocol <= '0;
          if (state == EMIT_BOT) begin
            if (prowAtLast) begin
              prow <= '0;
              chan <= chanAtLast ? '0 : chan + ChanW'(1);
            end else begin
              prow <= prow + ProwW'(1);
            end
          end
        end else begin
          ocol <= ocol + OcolW'(1);
        end
      end
    end
  end

  // Frame-complete pulse, one cycle after the final pixel of the last
  // channel is taken downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= acceptOut && frameEnd && chanAtLast;
    end
  end

`ifdef UNPOOL_NEAREST_EN
  // Row buffer write: the value only, because the index is not needed.
  always_ff @(posedge clk) begin
    if (acceptIn) begin
      bufData[col] <= in_data;
    end
  end
`else
  // Row buffer write: the value together with its argmax index.
  always_ff @(posedge clk) begin
    if (acceptIn) begin
      bufData[col] <= in_data;
      bufIdx[col]  <= in_idx;
    end
  end
`endif

  // Two adjacent output columns share one pooled entry.
  assign rdCol = ColW'(ocol >> 1);

`ifdef UNPOOL_NEAREST_EN
  assign pixel = bufData[rdCol];
`else
  // Window position of the current pixel: {bottom row, right column},
  // which uses the same encoding as in_idx.
  logic [1:0] position;
  assign position = {(state == EMIT_BOT), ocol[0]};
  assign pixel    = placePixel(bufData[rdCol], bufIdx[rdCol], position);
`endif

  // The output is forced to zero outside the EMIT states, so reset and FILL
  // present a clean zero. While stalled, every term feeding these outputs
  // is held, so the pixel and the last flag stay stable.
  assign out_data = emitting ? pixel : '0;
  assign out_last = frameEnd;

endmodule

// File: tb/tb_max_unpool_stream.sv
// Testbench for max_unpool_stream with a 4x4 output map.
// Two instances share one stimulus: dutA has Depth=1 and dutB has Depth=2.
// Both stay in lockstep; they differ only in when frame_done pulses.
module tb_max_unpool_stream;

  localparam int DW = 16;
  localparam int OH = 4;
  localparam int OW = 4;

  logic                 clk   = 1'b0;
  logic                 reset = 1'b0;
  logic                 inValid;
  logic signed [DW-1:0] inData;
  logic [1:0]           inIdx;
  logic                 outReady;

  logic                 inReadyA, outValidA, outLastA, frameDoneA;
  logic signed [DW-1:0] outDataA;
  logic                 inReadyB, outValidB, outLastB, frameDoneB;
  logic signed [DW-1:0] outDataB;

  int vecCnt = 0;
  int errCnt = 0;

  // Pooled stimulus: (5,0) (7,3) (-2,1) (9,2).
  logic signed [DW-1:0] tblData [4] = '{16'sd5, 16'sd7, -16'sd2, 16'sd9};
  logic [1:0]           tblIdx  [4] = '{2'd0, 2'd3, 2'd1, 2'd2};

  // Hand-computed 4x4 output map in raster order.
`ifdef UNPOOL_NEAREST_EN
  int expPix [16] = '{5, 5, 7, 7,   5, 5, 7, 7,   -2, -2, 9, 9,   -2, -2, 9, 9};
`else
  int expPix [16] = '{5, 0, 0, 0,   0, 0, 0, 7,   0, -2, 0, 0,   0, 0, 9, 0};
`endif

  always #5 clk = ~clk;

  max_unpool_stream #(.DATA_WIDTH(DW), .OutH(OH), .OutW(OW), .Depth(1)) dutA (
    .clk(clk), .reset(reset),
    .in_valid(inValid), .in_ready(inReadyA), .in_data(inData), .in_idx(inIdx),
    .out_valid(outValidA), .out_ready(outReady), .out_data(outDataA),
    .out_last(outLastA), .frame_done(frameDoneA)
  );

  max_unpool_stream #(.DATA_WIDTH(DW), .OutH(OH), .OutW(OW), .Depth(2)) dutB (
    .clk(clk), .reset(reset),
    .in_valid(inValid), .in_ready(inReadyB), .in_data(inData), .in_idx(inIdx),
    .out_valid(outValidB), .out_ready(outReady), .out_data(outDataB),
    .out_last(outLastB), .frame_done(frameDoneB)
  );

  task automatic checkVal(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, " outValidA"},  outValidA,  0);
    checkVal({tag, " outValidB"},  outValidB,  0);
    checkVal({tag, " inReadyA"},   inReadyA,   0);
    checkVal({tag, " outLastA"},   outLastA,   0);
    checkVal({tag, " frameDoneA"}, frameDoneA, 0);
    checkVal({tag, " frameDoneB"}, frameDoneB, 0);
    checkVal({tag, " outDataA"},   outDataA,   0);
    checkVal({tag, " outDataB"},   outDataB,   0);
  endtask

  task automatic doReset();
    inValid  = 1'b0;
    outReady = 1'b0;
    inData   = '0;
    inIdx    = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("post-reset inReadyA", inReadyA, 1);
  endtask

  // Stream until nPix pixels are taken. Inputs are driven on the falling edge
  // and outputs are sampled there. period sets the input spacing (1 means
  // every cycle). toggle applies out_ready = 1,0,0,1 repeating.
  task automatic runStream(input int nPix, input int period, input bit toggle);
    int nIn = 2 * ((nPix + 7) / 8);
    int inPtr = 0;
    int pix = 0;
    int cyc = 0;
    int lastFillCyc = -100;
    bit prevValid = 1'b0;
    bit prevReady = 1'b1;
    bit lastA = 1'b0;
    bit lastB = 1'b0;
    bit emitExp;
    logic signed [DW-1:0] held = '0;
    logic heldLast = 1'b0;
    while (pix < nPix && cyc < 1000) begin
      @(negedge clk);
      // A completed row pair exposes 8 pixels; emitting while any remain.
      emitExp = (pix < (inPtr / 2) * 8);
      checkVal("outValidA", outValidA, emitExp);
      checkVal("outValidB", outValidB, emitExp);
      checkVal("inReadyA", inReadyA, !emitExp);
      checkVal("inReadyB", inReadyB, !emitExp);
      checkVal("frameDoneA", frameDoneA, lastA);
      checkVal("frameDoneB", frameDoneB, lastB);
      if (prevValid && !prevReady) begin
        checkVal("stallData", outDataA, held);
        checkVal("stallLast", outLastA, heldLast);
      end
      if (outValidA && !prevValid) begin
        checkVal("firstPixLatency", cyc - lastFillCyc, 1);
      end
      outReady = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      inValid  = (inPtr < nIn) && (cyc % period == 0);
      inData   = tblData[inPtr % 4];
      inIdx    = tblIdx[inPtr % 4];
      lastA = 1'b0;
      lastB = 1'b0;
      if (outValidA && outReady) begin
        checkVal($sformatf("pixA%0d", pix), outDataA, expPix[pix % 16]);
        checkVal($sformatf("pixB%0d", pix), outDataB, expPix[pix % 16]);
        checkVal($sformatf("lastA%0d", pix), outLastA, (pix % 16 == 15));
        checkVal($sformatf("lastB%0d", pix), outLastB, (pix % 16 == 15));
        lastA = (pix % 16 == 15);
        lastB = (pix % 32 == 31);
        pix++;
      end
      if (inValid && inReadyA) begin
        inPtr++;
        if (inPtr % 2 == 0) lastFillCyc = cyc;
      end
      prevValid = outValidA;
      prevReady = outReady;
      held      = outDataA;
      heldLast  = outLastA;
      cyc++;
    end
    if (pix < nPix) checkVal("timeout pixels", pix, nPix);
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b0;
    @(negedge clk);
    checkVal("endFrameDoneA", frameDoneA, lastA);
    checkVal("endFrameDoneB", frameDoneB, lastB);
  endtask

  initial begin
    inValid  = 1'b0;
    outReady = 1'b0;
    inData   = '0;
    inIdx    = '0;

    // Basic frame, full rate.
    doReset();
    runStream(16, 1, 1'b0);

    // Output back-pressure 1,0,0,1.
    doReset();
    runStream(16, 1, 1'b1);

    // Input bubbles: valid every third cycle.
    doReset();
    runStream(16, 3, 1'b0);

    // Two channel maps: dutB pulses frame_done only after pixel 32.
    doReset();
    runStream(32, 1, 1'b0);

    // Reset asserted mid-cycle during the bottom row of row pair 0.
    doReset();
    runStream(6, 1, 1'b0);
    checkVal("preResetValidA", outValidA, 1);
    #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("asyncReset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("releaseInReadyA", inReadyA, 1);
    checkVal("releaseInReadyB", inReadyB, 1);
    runStream(16, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/max_unpool_stream.md
Name: max_unpool_stream

Overview:
- Streaming 2x2 max-unpooling block: the inverse of the 2x2 max-pool stage.
- Consumes pooled values in raster order, each paired with a 2-bit argmax index.
- Emits the 2x-upsampled feature map in raster order: the value is placed at its argmax position, all other positions are zero.
- Sits on the decoder/backward path after a max-pool stage; channels are processed sequentially, channel-major.

Parameters:
- DATA_WIDTH, 16, bits per element (signed fixed point, passed through untouched).
- OutH, 28, output map height; must be even. Pooled height is OutH/2.
- OutW, 28, output map width; must be even. Pooled width PoolW = OutW/2.
- Depth, 1, number of channels per frame.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  pooled element valid.
- in_ready  output  1  block accepts a pooled element.
- in_data  input  DATA_WIDTH  pooled value.
- in_idx  input  2  argmax position in the 2x2 window: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right.
- out_valid  output  1  output pixel valid.
- out_ready  input  1  downstream accepts the pixel.
- out_data  output  DATA_WIDTH  unpooled pixel.
- out_last  output  1  high with the final pixel of each channel map.
- frame_done  output  1  one-cycle pulse after the final pixel of channel Depth-1 is accepted.

Behaviour:
- Reset: asynchronous, active-high, as already decided. Any assertion, including mid-frame, forces:
  - state=FILL; all counters = 0;
  - in_ready=0 while reset is asserted;
  - out_valid=0, out_last=0, frame_done=0; out_data=0.
- Row buffer: PoolW entries of {data, idx}. Contents are not cleared; every entry is overwritten before it is read.
- Transfers complete only when valid&&ready are high on a rising edge.
- States:
  - FILL: in_ready=1, out_valid=0. Each accepted element is written to buffer[col]; col increments.
    - On acceptance with col==PoolW-1: col←0, go to EMIT_TOP.
  - EMIT_TOP: in_ready=0, out_valid=1. Pixel at ocol (0..OutW-1) = buffer[ocol/2].data if buffer[ocol/2].idx == (ocol%2), else 0.
    - On accepted pixel with ocol==OutW-1: ocol←0, go to EMIT_BOT.
  - EMIT_BOT: same as EMIT_TOP, but the compare is against 2+(ocol%2).
    - On accepted pixel with ocol==OutW-1:
      - if prow<OutH/2-1: prow++, go to FILL;
      - else: prow←0, out_last was high on this pixel, chan++, go to FILL.
      - If that was chan Depth-1: chan←0 and frame_done pulses the next cycle.
- Latency: first pixel of a row pair has out_valid high the cycle after the PoolW-th pooled element is accepted. No fill/emit overlap.
- Throughput: one pooled element per cycle in FILL, one pixel per cycle in EMIT while out_ready=1.
- Stall: while out_valid && !out_ready, out_data and out_last hold stable and counters hold.
- Gaps: in_valid may deassert at any time in FILL; the block waits with no data loss.
- out_last is high only on pixel (OutH-1, OutW-1) of each channel.
- Width: out_data is a direct copy of the stored value or all-zero; no arithmetic.

Optional Feature:
- Macro UNPOOL_NEAREST_EN.
- Defined:
  - in_idx is ignored and not stored (buffer holds data only).
  - Every output pixel = buffer[ocol/2].data in both EMIT_TOP and EMIT_BOT (nearest-neighbour 2x upsample).
- Undefined: argmax-placement behaviour as above.
- Handshake, latency and control are identical in both builds.

Test Plan:
- OutH=4, OutW=4, Depth=1; inputs (5,0),(7,3),(-2,1),(9,2) -> output rows 5,0,0,0 / 0,0,0,7 / 0,-2,0,0 / 0,0,9,0; out_last on 16th pixel; frame_done pulse one cycle later.
- Same stimulus, out_ready toggled 1,0,0,1 repeating -> identical pixel sequence; out_data stable across stalls; in_ready=0 throughout EMIT states.
- in_valid with bubbles (valid every 3rd cycle) in FILL -> first out_valid exactly one cycle after the 2nd row element is accepted; no duplicates or drops.
- Depth=2, 8 inputs -> 32 pixels; out_last on pixels 16 and 32; single frame_done pulse after pixel 32.
- Assert reset during EMIT_BOT of row pair 0 -> out_valid=0 immediately (asynchronous); after release in_ready=1 and a fresh frame decodes correctly.
- UNPOOL_NEAREST_EN defined, first test's inputs -> rows 5,5,7,7 / 5,5,7,7 / -2,-2,9,9 / -2,-2,9,9.
